mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port SRAM (CSN/WEN active-low, 1-cycle read latency) between the
//   RISC_TOY fetch side (IREQ/IADDR) and data side (DREQ/DRW/DADDR/DWDATA).
// - Grants one side per cycle, steers read data back and raises per-side stall.
// - Sits between the core top and a unified instruction/data SRAM.
// PARAMETERS
// - AW           10  SRAM word-address width; requesters' addresses are truncated to AW LSBs
// - BW           32  data width
// - MAX_D_BURST  4   consecutive data grants allowed while fetch waits (guard only), >=1
// PORTS
// - CLK       in   1   clock, rising edge
// - RSTN      in   1   synchronous active-low reset
// - I_REQ     in   1   fetch request, held with I_ADDR until I_GNT
// - I_ADDR    in   AW  fetch word address
// - I_GNT     out  1   fetch access issued this cycle
// - I_STALL   out  1   I_REQ & ~I_GNT
// - I_RVALID  out  1   I_RDATA valid (cycle after I_GNT)
// - I_RDATA   out  BW  fetch read data
// - D_REQ     in   1   data request, held with D_RW/D_ADDR/D_WDATA until D_GNT
// - D_RW      in   1   1 = write, 0 = read
// - D_ADDR    in   AW  data word address
// - D_WDATA   in   BW  store data
// - D_GNT     out  1   data access issued this cycle
// - D_STALL   out  1   D_REQ & ~D_GNT
// - D_RVALID  out  1   D_RDATA valid (cycle after a D read grant; never for writes)
// - D_RDATA   out  BW  load data
// - M_CSN     out  1   SRAM chip select, active low
// - M_WEN     out  1   SRAM write enable, active low
// - M_A       out  AW  SRAM address
// - M_DI      out  BW  SRAM write data
// - M_DOUT    in   BW  SRAM read data, valid cycle after read issue
// BEHAVIOUR
// - Grant is combinational from current requests and state; access issues in the grant cycle.
// - Priority: D over I (older instruction). Only D_REQ -> D; only I_REQ -> I; none -> M_CSN=1.
// - Memory drive: D grant -> M_A=D_ADDR, M_WEN=~D_RW, M_DI=D_WDATA; I grant -> M_A=I_ADDR,
//   M_WEN=1, M_DI=0; idle -> M_CSN=1, M_WEN=1, M_A=0, M_DI=0.
// - Return FSM (registered, records last cycle's issue): S_IDLE, S_IRD, S_DRD, S_DWR.
//   Next state = S_DWR on D write grant, S_DRD on D read grant, S_IRD on I grant, else S_IDLE.
//   Any state goes to any state every cycle; no multi-cycle occupancy.
// - I_RVALID = (state==S_IRD); D_RVALID = (state==S_DRD); X_RDATA = M_DOUT when X_RVALID,
//   else 0. Read latency exactly 1 cycle from grant, back-to-back grants allowed.
// - Write then read same address on consecutive cycles: read returns the new data (SRAM order).
// - Reset (RSTN=0 at edge): state=S_IDLE, guard counter=0; registered outputs I_RVALID/
//   D_RVALID=0, X_RDATA=0. Read issued in the cycle before reset is dropped (no RVALID).
//   Combinational outputs are forced while RSTN=0: I_GNT/D_GNT=0, M_CSN=1, M_WEN=1,
//   M_A=0, M_DI=0, stalls = requests.
// CONFIGURATION
// - MEM_ARB_STARVE_GUARD_EN defined: counter dcnt ($clog2(MAX_D_BURST+1) bits) increments on
//   each D grant while I_REQ=1, clears on I grant or when I_REQ=0. When dcnt==MAX_D_BURST and
//   I_REQ=1, I wins that cycle even if D_REQ=1 (D stalls one cycle), dcnt -> 0.
// - Not defined: pure D priority; counter absent; fetch may starve indefinitely.
// TESTING
// - I_REQ only, I_ADDR=0x004, mem[4]=0xDEADBEEF -> I_GNT same cycle, next cycle I_RVALID=1,
//   I_RDATA=0xDEADBEEF, D_RVALID=0.
// - I_REQ and D_REQ read 0x010 same cycle -> D_GNT=1, I_STALL=1; next cycle I_GNT=1 and
//   D_RVALID=1 with mem[0x10]; following cycle I_RVALID=1.
// - D write 0x020=0x12345678 then D read 0x020 back-to-back -> no D_RVALID after write,
//   D_RVALID with 0x12345678 two cycles after first grant.
// - RSTN=0 in cycle after an I read grant -> I_RVALID stays 0, M_CSN=1, state S_IDLE.
// - Guard on, MAX_D_BURST=4, D_REQ and I_REQ held 10 cycles -> grant pattern DDDDIDDDDI.
// - Guard off, same stimulus -> D granted all 10 cycles, I_STALL=1 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of one single-port SRAM with 1-cycle read latency.
// Optional fetch anti-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int AW          = 10,
  parameter int BW          = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_GNT,
  output logic          I_STALL,
  output logic          I_RVALID,
  output logic [BW-1:0] I_RDATA,
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [AW-1:0] D_ADDR,
  input  logic [BW-1:0] D_WDATA,
  output logic          D_GNT,
  output logic          D_STALL,
  output logic          D_RVALID,
  output logic [BW-1:0] D_RDATA,
  output logic          M_CSN,
  output logic          M_WEN,
  output logic [AW-1:0] M_A,
  output logic [BW-1:0] M_DI,
  input  logic [BW-1:0] M_DOUT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IRD  = 2'd1;
  localparam logic [1:0] S_DRD  = 2'd2;
  localparam logic [1:0] S_DWR  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       i_win;
  logic       d_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_D_BURST + 1);

  logic [CW-1:0] dcnt;
  logic          force_i;

  // After MAX_D_BURST data wins in a row, a waiting fetch takes one cycle.
  assign force_i = I_REQ && (dcnt == CW'(MAX_D_BURST));
  assign d_win   = D_REQ && !force_i;
  assign i_win   = I_REQ && (!D_REQ || force_i);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      dcnt <= '0;
    end else if (I_GNT || !I_REQ) begin
      dcnt <= '0;
    end else if (D_GNT) begin
      dcnt <= dcnt + CW'(1);
    end
  end
`else
  assign d_win = D_REQ;
  assign i_win = I_REQ && !D_REQ;
`endif

  // Stage 0: grant and SRAM access issue, combinational in the request cycle
  assign D_GNT   = RSTN && d_win;
  assign I_GNT   = RSTN && i_win;
  assign D_STALL = D_REQ && !D_GNT;
  assign I_STALL = I_REQ && !I_GNT;

  always_comb begin
    M_CSN     = 1'b1;
    M_WEN     = 1'b1;
    M_A       = '0;
    M_DI      = '0;
    state_nxt = S_IDLE;
    if (D_GNT) begin
      M_CSN     = 1'b0;
      M_WEN     = !D_RW;
      M_A       = D_ADDR;
      M_DI      = D_WDATA;
      state_nxt = D_RW ? S_DWR : S_DRD;
    end else if (I_GNT) begin
      M_CSN     = 1'b0;
      M_A       = I_ADDR;
      state_nxt = S_IRD;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage 1: return steering; a read issued just before reset never reports valid
  assign I_RVALID = RSTN && (state == S_IRD);
  assign D_RVALID = RSTN && (state == S_DRD);
  assign I_RDATA  = I_RVALID ? M_DOUT : '0;
  assign D_RDATA  = D_RVALID ? M_DOUT : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a behavioural SRAM and reference model.
module tb_mem_port_arbiter;

  localparam int AW          = 10;
  localparam int BW          = 32;
  localparam int MAX_D_BURST = 4;
  localparam int DEPTH       = 1 << AW;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt, i_stall, i_rvalid;
  logic [BW-1:0] i_rdata;
  logic          d_req, d_rw;
  logic [AW-1:0] d_addr;
  logic [BW-1:0] d_wdata;
  logic          d_gnt, d_stall, d_rvalid;
  logic [BW-1:0] d_rdata;
  logic          m_csn, m_wen;
  logic [AW-1:0] m_a;
  logic [BW-1:0] m_di;
  logic [BW-1:0] m_dout = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [BW-1:0] sram    [DEPTH];
  logic [BW-1:0] ref_mem [DEPTH];
  int            ret_who = 0;
  logic [BW-1:0] ret_val = '0;
  int            dwins   = 0;

  logic          obs_ig, obs_dg, obs_iv, obs_dv, obs_csn;
  logic [BW-1:0] obs_ird, obs_drd;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .BW(BW), .MAX_D_BURST(MAX_D_BURST)) dut (
    .CLK(clk), .RSTN(rstn),
    .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(i_gnt), .I_STALL(i_stall),
    .I_RVALID(i_rvalid), .I_RDATA(i_rdata),
    .D_REQ(d_req), .D_RW(d_rw), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_GNT(d_gnt), .D_STALL(d_stall), .D_RVALID(d_rvalid), .D_RDATA(d_rdata),
    .M_CSN(m_csn), .M_WEN(m_wen), .M_A(m_a), .M_DI(m_di), .M_DOUT(m_dout)
  );

  // Behavioural single-port SRAM, read data appears the cycle after issue
  always @(posedge clk) begin
    if (!m_csn) begin
      if (!m_wen) sram[m_a] <= m_di;
      else        m_dout    <= sram[m_a];
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: drive, check against the model mid-cycle, advance the model
  task automatic run_cycle(input logic rs, input logic ir, input logic [AW-1:0] ia,
                           input logic dr, input logic drw, input logic [AW-1:0] da,
                           input logic [BW-1:0] dw);
    logic e_ig, e_dg, force_i, e_iv, e_dv;
    rstn = rs; i_req = ir; i_addr = ia; d_req = dr; d_rw = drw; d_addr = da; d_wdata = dw;
    @(negedge clk);
    force_i = GUARD && ir && (dwins >= MAX_D_BURST);
    e_dg = rs && dr && !force_i;
    e_ig = rs && ir && (!dr || force_i);
    e_iv = rs && (ret_who == 1);
    e_dv = rs && (ret_who == 2);
    check_val("i_gnt",   64'(i_gnt),   64'(e_ig));
    check_val("d_gnt",   64'(d_gnt),   64'(e_dg));
    check_val("i_stall", 64'(i_stall), 64'(ir && !e_ig));
    check_val("d_stall", 64'(d_stall), 64'(dr && !e_dg));
    check_val("m_csn",   64'(m_csn),   64'(!(e_dg || e_ig)));
    check_val("m_wen",   64'(m_wen),   64'(!(e_dg && drw)));
    check_val("m_a",     64'(m_a),     64'(e_dg ? da : (e_ig ? ia : '0)));
    check_val("m_di",    64'(m_di),    64'(e_dg ? dw : '0));
    check_val("i_rvalid", 64'(i_rvalid), 64'(e_iv));
    check_val("d_rvalid", 64'(d_rvalid), 64'(e_dv));
    check_val("i_rdata", 64'(i_rdata), 64'(e_iv ? ret_val : '0));
    check_val("d_rdata", 64'(d_rdata), 64'(e_dv ? ret_val : '0));
    obs_ig = i_gnt; obs_dg = d_gnt; obs_iv = i_rvalid; obs_dv = d_rvalid;
    obs_csn = m_csn; obs_ird = i_rdata; obs_drd = d_rdata;
    if (!rs) begin
      ret_who = 0;
      dwins   = 0;
    end else if (e_dg) begin
      if (drw) begin
        ref_mem[da] = dw;
        ret_who = 0;
      end else begin
        ret_who = 2;
        ret_val = ref_mem[da];
      end
      dwins = ir ? dwins + 1 : 0;
    end else if (e_ig) begin
      ret_who = 1;
      ret_val = ref_mem[ia];
      dwins   = 0;
    end else begin
      ret_who = 0;
      dwins   = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0]    pat;
    logic [9:0]    pat_exp;
    logic          p_i, p_d, p_rw;
    logic [AW-1:0] p_ia, p_da;
    logic [BW-1:0] p_dw;
    logic          rs;

    for (int k = 0; k < DEPTH; k++) begin
      sram[k]    = $urandom;
      ref_mem[k] = sram[k];
    end
    sram[4]    = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;

    // Reset with both requests asserted: no grants, stalls mirror requests
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b1, 10'h3, 1'b1, 1'b1, 10'h5, 32'h1);
    run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Fetch-only read of word 4
    run_cycle(1'b1, 1'b1, 10'h004, 1'b0, 1'b0, '0, '0);
    check_val("t1_igrant", 64'(obs_ig), 64'(1));
    run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    check_val("t1_irvalid", 64'(obs_iv), 64'(1));
    check_val("t1_irdata", 64'(obs_ird), 64'(32'hDEADBEEF));
    check_val("t1_drvalid", 64'(obs_dv), 64'(0));

    // Simultaneous requests: data first, fetch next cycle
    run_cycle(1'b1, 1'b1, 10'h008, 1'b1, 1'b0, 10'h010, '0);
    check_val("t2_dgrant", 64'(obs_dg), 64'(1));
    run_cycle(1'b1, 1'b1, 10'h008, 1'b0, 1'b0, '0, '0);
    check_val("t2_igrant", 64'(obs_ig), 64'(1));
    check_val("t2_drdata", 64'(obs_drd), 64'(sram[10'h010]));
    run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    check_val("t2_irvalid", 64'(obs_iv), 64'(1));

    // Write then read same word back-to-back
    run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 10'h020, 32'h12345678);
    run_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h020, '0);
    check_val("t3_no_rvalid_after_wr", 64'(obs_dv), 64'(0));
    run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    check_val("t3_drdata", 64'(obs_drd), 64'(32'h12345678));

    // Reset right after a fetch grant drops the return
    run_cycle(1'b1, 1'b1, 10'h004, 1'b0, 1'b0, '0, '0);
    run_cycle(1'b0, 1'b1, 10'h004, 1'b0, 1'b0, '0, '0);
    check_val("t4_irvalid_rst", 64'(obs_iv), 64'(0));
    check_val("t4_csn_rst", 64'(obs_csn), 64'(1));
    run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    check_val("t4_irvalid_after", 64'(obs_iv), 64'(0));

    // Both requesters held for ten cycles
    pat_exp = GUARD ? 10'b1111011110 : 10'b1111111111;
    for (int k = 0; k < 10; k++) begin
      run_cycle(1'b1, 1'b1, 10'h040, 1'b1, 1'b0, 10'h041, '0);
      pat[9-k] = obs_dg;
    end
    check_val("burst_pattern", 64'(pat), 64'(pat_exp));
    run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Random traffic; requests held until granted, occasional reset
    p_i = 1'b0; p_d = 1'b0; p_rw = 1'b0; p_ia = '0; p_da = '0; p_dw = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!p_i && ($urandom_range(0, 2) != 0)) begin
        p_i  = 1'b1;
        p_ia = AW'($urandom_range(0, 31));
      end
      if (!p_d && ($urandom_range(0, 3) != 0)) begin
        p_d  = 1'b1;
        p_rw = 1'($urandom_range(0, 1));
        p_da = AW'($urandom_range(0, 31));
        p_dw = $urandom;
      end
      rs = ($urandom_range(0, 63) != 0);
      run_cycle(rs, p_i, p_ia, p_d, p_rw, p_da, p_dw);
      if (obs_ig) p_i = 1'b0;
      if (obs_dg) p_d = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
